// File: rtl/hazard_unit.sv
// hazard_unit: MIPS32 5-stage hazard detection, bypass selects and saturating stall counter
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [4:0]       rs_E,
   input  logic [4:0]       rt_E,
   input  logic             memtoreg_E,
   input  logic             memtoreg_M,
   input  logic             regwrite_E,
   input  logic             regwrite_M,
   input  logic             regwrite_W,
   input  logic             jrop_D,
   input  logic             beq_D,
   input  logic [4:0]       writereg_E,
   input  logic [4:0]       writereg_M,
   input  logic [4:0]       writereg_W,
   output logic             stop,
   output logic [1:0]       forward_AD,
   output logic [1:0]       forward_BD,
   output logic [1:0]       forward_AE,
   output logic [1:0]       forward_BE,
   output logic [CNT_W-1:0] stall_cnt
);
   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
   logic             lw_stall, br_stall, jr_stall;
   logic             me_rs_d, me_rt_d, mm_rs_d, mm_rt_d, mw_rs_d, mw_rt_d;
   logic             mm_rs_e, mm_rt_e, mw_rs_e, mw_rt_e;

   // $0 is hardwired zero, so it never matches a producer
   function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] r);
      return we && (wr == r) && (r != 5'd0);
   endfunction

   always_comb begin
      me_rs_d  = hit(regwrite_E, writereg_E, rs_D);
      me_rt_d  = hit(regwrite_E, writereg_E, rt_D);
      mm_rs_d  = hit(regwrite_M, writereg_M, rs_D);
      mm_rt_d  = hit(regwrite_M, writereg_M, rt_D);
      mw_rs_d  = hit(regwrite_W, writereg_W, rs_D);
      mw_rt_d  = hit(regwrite_W, writereg_W, rt_D);
      mm_rs_e  = hit(regwrite_M, writereg_M, rs_E);
      mm_rt_e  = hit(regwrite_M, writereg_M, rt_E);
      mw_rs_e  = hit(regwrite_W, writereg_W, rs_E);
      mw_rt_e  = hit(regwrite_W, writereg_W, rt_E);
      lw_stall = memtoreg_E && regwrite_E && (writereg_E != 5'd0) &&
                 ((writereg_E == rs_D) || (writereg_E == rt_D));
      // a load still in M has no data yet for the D-stage comparator
      br_stall = beq_D && (me_rs_d || me_rt_d || (memtoreg_M && (mm_rs_d || mm_rt_d)));
      jr_stall = jrop_D && (me_rs_d || (memtoreg_M && mm_rs_d));
      stop       = reset && (lw_stall || br_stall || jr_stall);
      forward_AE = !reset ? 2'b00 : mm_rs_e ? 2'b10 : mw_rs_e ? 2'b01 : 2'b00;
      forward_BE = !reset ? 2'b00 : mm_rt_e ? 2'b10 : mw_rt_e ? 2'b01 : 2'b00;
      forward_AD = !reset ? 2'b00 : (mm_rs_d && !memtoreg_M) ? 2'b10 : mw_rs_d ? 2'b01 : 2'b00;
      forward_BD = !reset ? 2'b00 : (mm_rt_d && !memtoreg_M) ? 2'b10 : mw_rt_d ? 2'b01 : 2'b00;
      stall_cnt_d = (stop && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed plus randomized checks of hazard_unit against a behavioural model
module tb_hazard_unit;
   localparam int CW = 6;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 0, reset = 0;
   logic [4:0]    rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
   logic          memtoreg_E, memtoreg_M, regwrite_E, regwrite_M, regwrite_W, jrop_D, beq_D;
   logic          stop;
   logic [1:0]    forward_AD, forward_BD, forward_AE, forward_BE;
   logic [CW-1:0] stall_cnt;
   int            n_chk = 0, n_err = 0, exp_cnt = 0;

   hazard_unit #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
      .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M), .regwrite_E(regwrite_E),
      .regwrite_M(regwrite_M), .regwrite_W(regwrite_W), .jrop_D(jrop_D), .beq_D(beq_D),
      .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
      .stop(stop), .forward_AD(forward_AD), .forward_BD(forward_BD),
      .forward_AE(forward_AE), .forward_BE(forward_BE), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // producer in stage s (0=E,1=M,2=W) writes register r, and r is a real register
   function automatic bit writes(input int s, input logic [4:0] r);
      if (r == 0) return 0;
      case (s)
         0: return regwrite_E && writereg_E == r;
         1: return regwrite_M && writereg_M == r;
         default: return regwrite_W && writereg_W == r;
      endcase
   endfunction

   function automatic int model_fe(input logic [4:0] r);
      if (writes(1, r)) return 2;
      if (writes(2, r)) return 1;
      return 0;
   endfunction

   function automatic int model_fd(input logic [4:0] r);
      if (writes(1, r) && !memtoreg_M) return 2;
      if (writes(2, r)) return 1;
      return 0;
   endfunction

   function automatic bit model_stop();
      bit lw, br, jr;
      if (!reset) return 0;
      lw = memtoreg_E && regwrite_E && writereg_E != 0 && (writereg_E == rs_D || writereg_E == rt_D);
      br = beq_D && (writes(0, rs_D) || writes(0, rt_D) || (memtoreg_M && (writes(1, rs_D) || writes(1, rt_D))));
      jr = jrop_D && (writes(0, rs_D) || (memtoreg_M && writes(1, rs_D)));
      return lw || br || jr;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) exp_cnt <= 0;
      else if (model_stop()) exp_cnt <= (exp_cnt < SAT) ? exp_cnt + 1 : SAT;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".stop"}, int'(stop), int'(model_stop()));
      check({tag, ".fAE"}, int'(forward_AE), reset ? model_fe(rs_E) : 0);
      check({tag, ".fBE"}, int'(forward_BE), reset ? model_fe(rt_E) : 0);
      check({tag, ".fAD"}, int'(forward_AD), reset ? model_fd(rs_D) : 0);
      check({tag, ".fBD"}, int'(forward_BD), reset ? model_fd(rt_D) : 0);
      check({tag, ".cnt"}, int'(stall_cnt), exp_cnt);
   endtask

   task automatic clear_inputs();
      {rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W} = '0;
      {memtoreg_E, memtoreg_M, regwrite_E, regwrite_M, regwrite_W, jrop_D, beq_D} = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      reset = 0;
      #12;
      check_all("reset");
      reset = 1;
      next_cycle();
      next_cycle();
      check_all("idle");
      check("idle.cnt0", int'(stall_cnt), 0);
      rs_E = 5; regwrite_M = 1; writereg_M = 5; regwrite_W = 1; writereg_W = 5;
      #1 check_all("m_over_w");
      check("m_over_w.fAE", int'(forward_AE), 2);
      writereg_M = 6;
      #1 check("w_fwd.fAE", int'(forward_AE), 1);
      clear_inputs();
      regwrite_M = 1; regwrite_W = 1;
      #1 check_all("zero_reg");
      check("zero_reg.fBE", int'(forward_BE), 0);
      clear_inputs();
      memtoreg_E = 1; regwrite_E = 1; writereg_E = 8; rt_D = 8;
      #1 check("lw.stop", int'(stop), 1);
      repeat (3) next_cycle();
      check_all("lw3");
      check("lw3.cnt", int'(stall_cnt), 3);
      clear_inputs();
      beq_D = 1; rs_D = 9; regwrite_E = 1; writereg_E = 9;
      #1 check("beq_E.stop", int'(stop), 1);
      beq_D = 0; jrop_D = 1; rt_D = 9; rs_D = 1;
      #1 check("jr_rt.stop", int'(stop), 0);
      clear_inputs();
      beq_D = 1; rt_D = 4; regwrite_M = 1; writereg_M = 4;
      #1 check_all("beq_M_alu");
      check("beq_M_alu.fBD", int'(forward_BD), 2);
      memtoreg_M = 1;
      #1 check_all("beq_M_load");
      check("beq_M_load.stop", int'(stop), 1);
      next_cycle();
      #2 reset = 0;
      #1 check_all("async_rst");
      check("async_rst.cnt", int'(stall_cnt), 0);
      next_cycle();
      reset = 1;
      repeat (SAT + 8) next_cycle();
      check_all("saturate");
      check("saturate.cnt", int'(stall_cnt), SAT);
      for (int i = 0; i < 600; i++) begin
         next_cycle();
         reset      = ($urandom_range(0, 49) != 0);
         rs_D       = 5'($urandom_range(0, 3));
         rt_D       = 5'($urandom_range(0, 3));
         rs_E       = 5'($urandom_range(0, 3));
         rt_E       = 5'($urandom_range(0, 3));
         writereg_E = 5'($urandom_range(0, 3));
         writereg_M = 5'($urandom_range(0, 3));
         writereg_W = 5'($urandom_range(0, 3));
         memtoreg_E = 1'($urandom);
         memtoreg_M = 1'($urandom);
         regwrite_E = 1'($urandom);
         regwrite_M = 1'($urandom);
         regwrite_W = 1'($urandom);
         jrop_D     = 1'($urandom);
         beq_D      = 1'($urandom);
         @(negedge clk);
         check_all("rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
